// File: rtl/health_round_manager_pkg.sv
// Shared types for the health/round manager: state encodings, attack codes, damage lookup.
package health_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'b000,
        StFight   = 3'b001,
        StKoP1    = 3'b010,
        StKoP2    = 3'b011,
        StDraw    = 3'b100,
        StMatchP1 = 3'b101,
        StMatchP2 = 3'b110
    } state_e;

    localparam logic [1:0] ATK_NONE  = 2'b00;
    localparam logic [1:0] ATK_LIGHT = 2'b01;
    localparam logic [1:0] ATK_MED   = 2'b10;
    localparam logic [1:0] ATK_HEAVY = 2'b11;

    function automatic int unsigned dmg_lookup(logic [1:0] attack, int unsigned light,
                                               int unsigned med, int unsigned heavy);
        int unsigned d;
        unique case (attack)
            ATK_LIGHT: d = light;
            ATK_MED:   d = med;
            ATK_HEAVY: d = heavy;
            default:   d = 0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/health_round_manager_if.sv
// Game-side signal bundle of the health/round manager.
// ROUND_TIMER_EN adds tick_1hz and time_left.
interface health_round_manager_if #(
    parameter int unsigned HEALTH_W = 9,
    parameter int unsigned WIN_W    = 2
);
    logic                round_start;
    logic                p1_hit;
    logic                p2_hit;
    logic [1:0]          p1_attack;
    logic [1:0]          p2_attack;
    logic                p1_block;
    logic                p2_block;
    logic [HEALTH_W-1:0] health_1;
    logic [HEALTH_W-1:0] health_2;
    logic [WIN_W-1:0]    wins_1;
    logic [WIN_W-1:0]    wins_2;
    logic [2:0]          state;
    logic                round_over;
`ifdef ROUND_TIMER_EN
    logic                tick_1hz;
    logic [6:0]          time_left;

    modport slave (
        input  round_start, p1_hit, p2_hit, p1_attack, p2_attack, p1_block, p2_block, tick_1hz,
        output health_1, health_2, wins_1, wins_2, state, round_over, time_left
    );
    modport master (
        output round_start, p1_hit, p2_hit, p1_attack, p2_attack, p1_block, p2_block, tick_1hz,
        input  health_1, health_2, wins_1, wins_2, state, round_over, time_left
    );
`else
    modport slave (
        input  round_start, p1_hit, p2_hit, p1_attack, p2_attack, p1_block, p2_block,
        output health_1, health_2, wins_1, wins_2, state, round_over
    );
    modport master (
        output round_start, p1_hit, p2_hit, p1_attack, p2_attack, p1_block, p2_block,
        input  health_1, health_2, wins_1, wins_2, state, round_over
    );
`endif
endinterface

// File: rtl/fighter_health.sv
// One fighter's health register, incoming-hit gate, chip damage and invulnerability window.
module fighter_health
    import health_pkg::*;
#(
    parameter int unsigned HEALTH_W      = 9,
    parameter int unsigned MAX_HEALTH    = 400,
    parameter int unsigned DMG_LIGHT     = 4,
    parameter int unsigned DMG_MED       = 10,
    parameter int unsigned DMG_HEAVY     = 20,
    parameter int unsigned CHIP_SHIFT    = 2,
    parameter int unsigned INVULN_CYCLES = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reload,
    input  logic                fight,
    input  logic                hit,
    input  logic [1:0]          attack,
    input  logic                block,
    output logic [HEALTH_W-1:0] health,
    output logic [HEALTH_W-1:0] next_health
);
    localparam int unsigned INV_W = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;

    logic [HEALTH_W-1:0] health_q;
    logic [HEALTH_W-1:0] dmg;
    logic [INV_W-1:0]    invuln_q;
    logic [INV_W-1:0]    invuln_d;
    logic                accepted;
    int unsigned         raw;

    always_comb begin
        raw = dmg_lookup(attack, DMG_LIGHT, DMG_MED, DMG_HEAVY);
        if (block) begin
            raw = raw >> CHIP_SHIFT;
        end
        dmg      = HEALTH_W'(raw);
        accepted = fight && hit && (attack != ATK_NONE) && (invuln_q == '0);

        next_health = health_q;
        invuln_d    = invuln_q;
        if (invuln_q != '0) begin
            invuln_d = invuln_q - 1'b1;
        end
        if (reload) begin
            next_health = HEALTH_W'(MAX_HEALTH);
            invuln_d    = '0;
        end else if (accepted) begin
            // A zero chip still lands and still grants immunity.
            next_health = (health_q > dmg) ? health_q - dmg : '0;
            invuln_d    = INV_W'(INVULN_CYCLES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            health_q <= HEALTH_W'(MAX_HEALTH);
            invuln_q <= '0;
        end else begin
            health_q <= next_health;
            invuln_q <= invuln_d;
        end
    end

    assign health = health_q;

endmodule

// File: rtl/health_round_manager.sv
// Two-fighter health tracker with best-of-N round/match FSM.
// ROUND_TIMER_EN adds a per-round countdown resolved by remaining health.
module health_round_manager
    import health_pkg::*;
#(
    parameter int unsigned HEALTH_W       = 9,
    parameter int unsigned MAX_HEALTH     = 400,
    parameter int unsigned DMG_LIGHT      = 4,
    parameter int unsigned DMG_MED        = 10,
    parameter int unsigned DMG_HEAVY      = 20,
    parameter int unsigned CHIP_SHIFT     = 2,
    parameter int unsigned INVULN_CYCLES  = 30,
    parameter int unsigned KO_HOLD_CYCLES = 120,
    parameter int unsigned WINS_TO_MATCH  = 2,
    parameter int unsigned WIN_W          = 2
`ifdef ROUND_TIMER_EN
    ,
    parameter int unsigned ROUND_SECONDS  = 99
`endif
) (
    input logic                    clk,
    input logic                    reset,
    health_round_manager_if.slave  bus
);
    localparam int unsigned HOLD_W = $clog2(KO_HOLD_CYCLES + 1);
    localparam logic [WIN_W-1:0] WIN_MAX = '1;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [WIN_W-1:0]    wins_1_q, wins_1_d, wins_2_q, wins_2_d;
    logic                round_over_q, round_over_d;
    logic                reload, fight;
    logic                p1_wins, p2_wins;
    logic [HEALTH_W-1:0] health_1, health_2, next_1, next_2;
`ifdef ROUND_TIMER_EN
    logic [6:0]          time_q, time_d;
`endif

    assign reload = (state_q == StIdle) && bus.round_start;
    assign fight  = (state_q == StFight);

    fighter_health #(
        .HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .DMG_LIGHT(DMG_LIGHT), .DMG_MED(DMG_MED),
        .DMG_HEAVY(DMG_HEAVY), .CHIP_SHIFT(CHIP_SHIFT), .INVULN_CYCLES(INVULN_CYCLES)
    ) u_p1 (
        .clk(clk), .reset(reset), .reload(reload), .fight(fight), .hit(bus.p2_hit),
        .attack(bus.p2_attack), .block(bus.p1_block), .health(health_1), .next_health(next_1)
    );

    fighter_health #(
        .HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .DMG_LIGHT(DMG_LIGHT), .DMG_MED(DMG_MED),
        .DMG_HEAVY(DMG_HEAVY), .CHIP_SHIFT(CHIP_SHIFT), .INVULN_CYCLES(INVULN_CYCLES)
    ) u_p2 (
        .clk(clk), .reset(reset), .reload(reload), .fight(fight), .hit(bus.p1_hit),
        .attack(bus.p1_attack), .block(bus.p2_block), .health(health_2), .next_health(next_2)
    );

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        wins_1_d     = wins_1_q;
        wins_2_d     = wins_2_q;
        round_over_d = 1'b0;
        p1_wins      = (next_2 == '0);
        p2_wins      = (next_1 == '0);
`ifdef ROUND_TIMER_EN
        time_d = time_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.round_start) begin
                    state_d = StFight;
`ifdef ROUND_TIMER_EN
                    time_d  = 7'(ROUND_SECONDS);
`endif
                end
            end
            StFight: begin
`ifdef ROUND_TIMER_EN
                // Timeout only decides the round when no KO landed this cycle.
                if (!p1_wins && !p2_wins && time_q == '0) begin
                    p1_wins = (next_1 >= next_2);
                    p2_wins = (next_2 >= next_1);
                end else if (bus.tick_1hz && time_q != '0) begin
                    time_d = time_q - 1'b1;
                end
`endif
                if (p1_wins || p2_wins) begin
                    round_over_d = 1'b1;
                    hold_d       = '0;
                    if (p1_wins && p2_wins) begin
                        state_d = StDraw;
                    end else if (p1_wins) begin
                        state_d = StKoP1;
                        if (wins_1_q != WIN_MAX) wins_1_d = wins_1_q + 1'b1;
                    end else begin
                        state_d = StKoP2;
                        if (wins_2_q != WIN_MAX) wins_2_d = wins_2_q + 1'b1;
                    end
                end
            end
            StKoP1, StKoP2, StDraw: begin
                if (hold_q == HOLD_W'(KO_HOLD_CYCLES - 1)) begin
                    hold_d = '0;
                    if (int'(wins_1_q) >= int'(WINS_TO_MATCH)) begin
                        state_d = StMatchP1;
                    end else if (int'(wins_2_q) >= int'(WINS_TO_MATCH)) begin
                        state_d = StMatchP2;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StMatchP1, StMatchP2: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            wins_1_q     <= '0;
            wins_2_q     <= '0;
            round_over_q <= 1'b0;
`ifdef ROUND_TIMER_EN
            time_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            wins_1_q     <= wins_1_d;
            wins_2_q     <= wins_2_d;
            round_over_q <= round_over_d;
`ifdef ROUND_TIMER_EN
            time_q       <= time_d;
`endif
        end
    end

    assign bus.health_1   = health_1;
    assign bus.health_2   = health_2;
    assign bus.wins_1     = wins_1_q;
    assign bus.wins_2     = wins_2_q;
    assign bus.state      = state_q;
    assign bus.round_over = round_over_q;
`ifdef ROUND_TIMER_EN
    assign bus.time_left  = time_q;
`endif

endmodule
